// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle RV64-subset control sequencer (R, ld, sd, beq)
// Optional illegal-opcode trap: define MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN.
module multicycle_control #(
    parameter logic [6:0] OPC_R   = 7'b0110011,
    parameter logic [6:0] OPC_LD  = 7'b0000011,
    parameter logic [6:0] OPC_SD  = 7'b0100011,
    parameter logic [6:0] OPC_BEQ = 7'b1100011
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] aluop,
    output logic       pc_source,
    output logic       retire,
    output logic [3:0] state
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
    ,
    output logic       illegal
`endif
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_LDWB    = 4'd4,
        S_MEMWR   = 4'd5,
        S_REXEC   = 4'd6,
        S_REGWB   = 4'd7,
        S_BEQEX   = 4'd8,
        S_ILLEGAL = 4'd9
    } state_t;

    state_t     state_q, state_d;
    logic [6:0] op_q, op_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            op_q    <= 7'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    assign state = rst_n ? state_q : S_FETCH;

    always_comb begin
        state_d    = S_FETCH;
        op_d       = op_q;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        aluop      = 2'b00;
        pc_source  = 1'b0;
        retire     = 1'b0;
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
        illegal    = 1'b0;
`endif
        // Reset masks every enable so an aborted instruction leaves no pulse behind.
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                    state_d   = mem_ready ? S_DECODE : S_FETCH;
                end
                S_DECODE: begin
                    alu_src_b = 2'b10;
                    op_d      = opcode;
                    if (opcode == OPC_LD || opcode == OPC_SD) begin
                        state_d = S_MEMADR;
                    end else if (opcode == OPC_R) begin
                        state_d = S_REXEC;
                    end else if (opcode == OPC_BEQ) begin
                        state_d = S_BEQEX;
                    end else begin
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
                        state_d = S_ILLEGAL;
`else
                        retire  = 1'b1;
                        state_d = S_FETCH;
`endif
                    end
                end
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    state_d   = (op_q == OPC_LD) ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                    state_d  = mem_ready ? S_LDWB : S_MEMRD;
                end
                S_LDWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    retire     = 1'b1;
                end
                S_MEMWR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                    retire    = mem_ready;
                    state_d   = mem_ready ? S_FETCH : S_MEMWR;
                end
                S_REXEC: begin
                    alu_src_a = 1'b1;
                    aluop     = 2'b10;
                    state_d   = S_REGWB;
                end
                S_REGWB: begin
                    reg_write = 1'b1;
                    retire    = 1'b1;
                end
                S_BEQEX: begin
                    alu_src_a = 1'b1;
                    aluop     = 2'b01;
                    pc_source = 1'b1;
                    pc_write  = zero;
                    retire    = 1'b1;
                end
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
                S_ILLEGAL: begin
                    illegal = 1'b1;
                    state_d = S_ILLEGAL;
                end
`endif
                default: state_d = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control against a per-instruction schedule model
module tb_multicycle_control;

    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_LD  = 7'b0000011;
    localparam logic [6:0] OPC_SD  = 7'b0100011;
    localparam logic [6:0] OPC_BEQ = 7'b1100011;

    // Control vector bit positions: {pc_write, ir_write, mem_read, mem_write, iord,
    // mem_to_reg, reg_write, alu_src_a, alu_src_b[1:0], aluop[1:0], pc_source, retire}
    localparam logic [13:0] PCW  = 14'h2000;
    localparam logic [13:0] IRW  = 14'h1000;
    localparam logic [13:0] MRD  = 14'h0800;
    localparam logic [13:0] MWR  = 14'h0400;
    localparam logic [13:0] IORD = 14'h0200;
    localparam logic [13:0] MTR  = 14'h0100;
    localparam logic [13:0] RW   = 14'h0080;
    localparam logic [13:0] SA   = 14'h0040;
    localparam logic [13:0] B4   = 14'h0010;
    localparam logic [13:0] BIMM = 14'h0020;
    localparam logic [13:0] SUB  = 14'h0004;
    localparam logic [13:0] FN   = 14'h0008;
    localparam logic [13:0] PCS  = 14'h0002;
    localparam logic [13:0] RET  = 14'h0001;

    logic       clk = 1'b0;
    logic       rst_n, zero, mem_ready;
    logic [6:0] opcode;
    logic       pc_write, ir_write, mem_read, mem_write, iord, mem_to_reg, reg_write;
    logic       alu_src_a, pc_source, retire;
    logic [1:0] alu_src_b, aluop;
    logic [3:0] state;
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
    logic       illegal;
`endif

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .iord       (iord),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .aluop      (aluop),
        .pc_source  (pc_source),
        .retire     (retire),
        .state      (state)
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
        ,
        .illegal    (illegal)
`endif
    );

    typedef struct {
        logic        rst;
        logic [3:0]  st;
        logic        mr;
        logic        z;
        logic [6:0]  opc;
        logic [13:0] ctl;
    } step_t;

    step_t sched[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    cyc = 0;

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [6:0] ro();
        return 7'($urandom);
    endfunction

    function automatic void push(input logic rst, input logic [3:0] st, input logic mr,
                                 input logic z, input logic [6:0] opc, input logic [13:0] ctl);
        step_t s;
        s.rst = rst; s.st = st; s.mr = mr; s.z = z; s.opc = opc; s.ctl = ctl;
        sched.push_back(s);
    endfunction

    function automatic bit known_op(input logic [6:0] op);
        return (op == OPC_R) || (op == OPC_LD) || (op == OPC_SD) || (op == OPC_BEQ);
    endfunction

    // Expected cycle-by-cycle schedule of one instruction; opcode is garbage outside DECODE.
    function automatic void add_instr(input logic [6:0] op, input int wf, input int wm, input logic z);
        logic [13:0] dec;
        for (int i = 0; i < wf; i++) push(1'b1, 4'd0, 1'b0, rb(), ro(), MRD | B4);
        push(1'b1, 4'd0, 1'b1, rb(), ro(), MRD | B4 | IRW | PCW);
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
        dec = BIMM;
`else
        dec = known_op(op) ? BIMM : (BIMM | RET);
`endif
        push(1'b1, 4'd1, rb(), rb(), op, dec);
        if (op == OPC_R) begin
            push(1'b1, 4'd6, rb(), rb(), ro(), SA | FN);
            push(1'b1, 4'd7, rb(), rb(), ro(), RW | RET);
        end else if (op == OPC_LD) begin
            push(1'b1, 4'd2, rb(), rb(), ro(), SA | BIMM);
            for (int i = 0; i < wm; i++) push(1'b1, 4'd3, 1'b0, rb(), ro(), MRD | IORD);
            push(1'b1, 4'd3, 1'b1, rb(), ro(), MRD | IORD);
            push(1'b1, 4'd4, rb(), rb(), ro(), RW | MTR | RET);
        end else if (op == OPC_SD) begin
            push(1'b1, 4'd2, rb(), rb(), ro(), SA | BIMM);
            for (int i = 0; i < wm; i++) push(1'b1, 4'd5, 1'b0, rb(), ro(), MWR | IORD);
            push(1'b1, 4'd5, 1'b1, rb(), ro(), MWR | IORD | RET);
        end else if (op == OPC_BEQ) begin
            push(1'b1, 4'd8, rb(), z, ro(), SA | SUB | PCS | RET | (z ? PCW : 14'h0));
        end else begin
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
            for (int i = 0; i < 10; i++) push(1'b1, 4'd9, rb(), rb(), ro(), 14'h0);
            push(1'b0, 4'd0, rb(), rb(), ro(), 14'h0);
`endif
        end
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic run_sched();
        step_t s;
        while (sched.size() > 0) begin
            s = sched.pop_front();
            @(posedge clk);
            #1;
            rst_n     = s.rst;
            mem_ready = s.mr;
            zero      = s.z;
            opcode    = s.opc;
            @(negedge clk);
            cyc++;
            chk("state", {12'h0, state}, {12'h0, s.st});
            chk("ctl", {2'b00, pc_write, ir_write, mem_read, mem_write, iord, mem_to_reg,
                        reg_write, alu_src_a, alu_src_b, aluop, pc_source, retire},
                {2'b00, s.ctl});
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
            chk("illegal", {15'h0, illegal}, {15'h0, (s.rst && s.st == 4'd9)});
`endif
        end
    endtask

    initial begin
        logic [6:0] op;
        rst_n = 1'b0; mem_ready = 1'b1; opcode = OPC_R; zero = 1'b0;

        push(1'b0, 4'd0, 1'b1, 1'b0, OPC_R, 14'h0);
        push(1'b0, 4'd0, 1'b1, 1'b0, OPC_R, 14'h0);
        add_instr(OPC_R, 0, 0, 1'b0);
        add_instr(OPC_LD, 0, 2, 1'b0);
        add_instr(OPC_SD, 0, 0, 1'b0);
        add_instr(OPC_BEQ, 0, 0, 1'b1);
        add_instr(OPC_BEQ, 1, 0, 1'b0);

        // Reset lands while a store is waiting on memory.
        push(1'b1, 4'd0, 1'b1, rb(), ro(), MRD | B4 | IRW | PCW);
        push(1'b1, 4'd1, rb(), rb(), OPC_SD, BIMM);
        push(1'b1, 4'd2, rb(), rb(), ro(), SA | BIMM);
        push(1'b1, 4'd5, 1'b0, rb(), ro(), MWR | IORD);
        push(1'b0, 4'd0, 1'b0, rb(), ro(), 14'h0);
        add_instr(OPC_SD, 1, 0, 1'b0);

        add_instr(7'h7F, 0, 0, 1'b0);
        add_instr(OPC_R, 0, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 4))
                0: op = OPC_R;
                1: op = OPC_LD;
                2: op = OPC_SD;
                3: op = OPC_BEQ;
                default: begin
                    op = ro();
                    while (known_op(op)) op = ro();
                end
            endcase
            add_instr(op, $urandom_range(0, 2), $urandom_range(0, 2), rb());
        end

        run_sched();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
